// File: rtl/ubcd_pkg.sv
// Shared constants for the multi-digit universal decoder: mode encodings,
// register addresses, CTRL bit positions and the 7-segment hex table.
package ubcd_pkg;

    // Code-table selection carried in CTRL[1:0]; encoding 3 decodes as hex.
    localparam logic [1:0] MODE_RAW = 2'd0;
    localparam logic [1:0] MODE_HEX = 2'd1;
    localparam logic [1:0] MODE_BCD = 2'd2;

    // Register addresses above the digit bank.
    localparam logic [3:0] ADDR_CTRL   = 4'h8;
    localparam logic [3:0] ADDR_PRE_LO = 4'h9;
    localparam logic [3:0] ADDR_PRE_HI = 4'hA;
    localparam logic [3:0] ADDR_INDEX  = 4'hB;

    // CTRL bit positions.
    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_SCAN_EN  = 2;
    localparam int CTRL_INVERT   = 3;
    localparam int CTRL_LZB      = 4;

    // Segment patterns {g,f,e,d,c,b,a} for codes 0..F; entry 0 is rightmost.
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/ubcd_seg_decode.sv
// Combinational code-to-segment decoder for one digit. Blanking applies only
// in the hex and BCD tables; raw mode always passes the code through.
module ubcd_seg_decode
    import ubcd_pkg::*;
(
    input  logic [3:0] code,
    input  logic [1:0] mode,
    input  logic       blank,
    output logic [6:0] seg
);

    // Table lookup selected by the current mode.
    always_comb begin
        seg = 7'h00;
        case (mode)
            MODE_RAW: seg = {3'b000, code};
            MODE_BCD: begin
                if (blank) begin
                    seg = 7'h00;
                end else if (code <= 4'd9) begin
                    seg = HEX_TABLE[code];
                end else begin
                    seg = 7'h00;
                end
            end
            default: begin
                if (blank) begin
                    seg = 7'h00;
                end else begin
                    seg = HEX_TABLE[code];
                end
            end
        endcase
    end

endmodule

// File: rtl/tqvp_rebeccargb_ubcd_scan.sv
// Multi-digit scanned 7-segment decoder peripheral for the TinyQV bus.
// Optional leading-zero blanking is built when UBCD_LZB_EN is defined.
module tqvp_rebeccargb_ubcd_scan
    import ubcd_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            ui_in,
    output logic [7:0]            uo_out,
    output logic [NUM_DIGITS-1:0] digit_sel,
    input  logic [3:0]            address,
    input  logic                  data_write,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out
);

`ifdef UBCD_LZB_EN
    localparam logic [7:0] CTRL_WMASK = 8'h1F;
`else
    localparam logic [7:0] CTRL_WMASK = 8'h0F;
`endif

    logic [7:0]            digit_q [NUM_DIGITS];
    logic [7:0]            digit_d [NUM_DIGITS];
    logic [7:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            uo_q, uo_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;

    logic [15:0]           pre_wr_s;
    logic [15:0]           pre_rd_s;
    logic                  scan_en_s;
    logic                  invert_s;
    logic [2:0]            cur_idx_s;
    logic [3:0]            cur_code_s;
    logic                  cur_dp_s;
    logic [NUM_DIGITS-1:0] sel_oh_s;
    logic                  blank_s;
    logic [6:0]            seg_s;
    logic                  unused_ui_s;

    assign unused_ui_s = ^ui_in;
    assign scan_en_s   = ctrl_q[CTRL_SCAN_EN];
    assign invert_s    = ctrl_q[CTRL_INVERT];
    assign pre_rd_s    = 16'(pre_q);
    // With scanning off the display is pinned to DIGIT0 even before idx_q clears.
    assign cur_idx_s   = scan_en_s ? idx_q : 3'd0;

    // Bus writes into digit, control and prescale registers.
    always_comb begin
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (data_write && (address == 4'(j))) begin
                digit_d[j] = {data_in[7], 3'b000, data_in[3:0]};
            end else begin
                digit_d[j] = digit_q[j];
            end
        end
        if (data_write && (address == ADDR_CTRL)) begin
            ctrl_d = data_in & CTRL_WMASK;
        end else begin
            ctrl_d = ctrl_q;
        end
        pre_wr_s = 16'(pre_q);
        if (data_write) begin
            case (address)
                ADDR_PRE_LO: pre_wr_s[7:0]  = data_in;
                ADDR_PRE_HI: pre_wr_s[15:8] = data_in;
                default:     pre_wr_s       = 16'(pre_q);
            endcase
        end else begin
            pre_wr_s = 16'(pre_q);
        end
        pre_d = pre_wr_s[PRESCALE_W-1:0];
    end

    // Prescaler and scan index; both held at zero while scanning is off.
    always_comb begin
        cnt_d = '0;
        idx_d = 3'd0;
        if (scan_en_s) begin
            if (cnt_q >= pre_q) begin
                cnt_d = '0;
                idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : (idx_q + 3'd1);
            end else begin
                cnt_d = cnt_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
                idx_d = idx_q;
            end
        end else begin
            cnt_d = '0;
            idx_d = 3'd0;
        end
    end

    // Pick the digit at the displayed position and build its one-hot select.
    always_comb begin
        cur_code_s = 4'h0;
        cur_dp_s   = 1'b0;
        sel_oh_s   = '0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (cur_idx_s == 3'(j)) begin
                cur_code_s  = digit_q[j][3:0];
                cur_dp_s    = digit_q[j][7];
                sel_oh_s[j] = 1'b1;
            end else begin
                sel_oh_s[j] = 1'b0;
            end
        end
    end

`ifdef UBCD_LZB_EN
    logic zero_run_s;

    // A digit is a leading zero when it and every more significant code are 0.
    always_comb begin
        zero_run_s = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (3'(j) >= cur_idx_s) begin
                zero_run_s = zero_run_s & (digit_q[j][3:0] == 4'h0);
            end else begin
                zero_run_s = zero_run_s;
            end
        end
        blank_s = ctrl_q[CTRL_LZB] & (cur_idx_s != 3'd0) & zero_run_s;
    end
`else
    assign blank_s = 1'b0;
`endif

    ubcd_seg_decode u_seg_decode (
        .code  (cur_code_s),
        .mode  (ctrl_q[CTRL_MODE_LSB +: 2]),
        .blank (blank_s),
        .seg   (seg_s)
    );

    // Next display outputs with optional polarity inversion for common-anode parts.
    always_comb begin
        uo_d  = {cur_dp_s, seg_s} ^ {8{invert_s}};
        sel_d = sel_oh_s ^ {NUM_DIGITS{invert_s}};
    end

    // Combinational register readback.
    always_comb begin
        data_out = 8'h00;
        case (address)
            ADDR_CTRL:   data_out = ctrl_q;
            ADDR_PRE_LO: data_out = pre_rd_s[7:0];
            ADDR_PRE_HI: data_out = pre_rd_s[15:8];
            ADDR_INDEX:  data_out = {5'b00000, idx_q};
            default: begin
                for (int j = 0; j < NUM_DIGITS; j++) begin
                    if (address == 4'(j)) begin
                        data_out = digit_q[j];
                    end else begin
                        data_out = data_out;
                    end
                end
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                digit_q[j] <= 8'h00;
            end
            ctrl_q <= 8'h00;
            pre_q  <= '1;
            cnt_q  <= '0;
            idx_q  <= 3'd0;
            uo_q   <= 8'h00;
            sel_q  <= '0;
        end else begin
            for (int j = 0; j < NUM_DIGITS; j++) begin
                digit_q[j] <= digit_d[j];
            end
            ctrl_q <= ctrl_d;
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            uo_q   <= uo_d;
            sel_q  <= sel_d;
        end
    end

    assign uo_out    = uo_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_tqvp_rebeccargb_ubcd_scan.sv
// Self-checking bench for tqvp_rebeccargb_ubcd_scan (default parameters).
// Honours UBCD_LZB_EN the same way as the design.
module tb_tqvp_rebeccargb_ubcd_scan;

    localparam int N = 4;
`ifdef UBCD_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif
    localparam logic [6:0] SEG_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   ui_in;
    logic [7:0]   uo_out;
    logic [N-1:0] digit_sel;
    logic [3:0]   address;
    logic         data_write;
    logic [7:0]   data_in;
    logic [7:0]   data_out;

    int n_checks = 0;
    int n_errors = 0;

    tqvp_rebeccargb_ubcd_scan #(.NUM_DIGITS(N), .PRESCALE_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .ui_in      (ui_in),
        .uo_out     (uo_out),
        .digit_sel  (digit_sel),
        .address    (address),
        .data_write (data_write),
        .data_in    (data_in),
        .data_out   (data_out)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [7:0]   m_dig [N];
    logic [7:0]   m_ctrl;
    logic [15:0]  m_pre;
    logic [15:0]  m_cnt;
    int           m_idx;
    logic [7:0]   exp_uo;
    logic [N-1:0] exp_sel;

    function automatic logic [6:0] ref_seg(input logic [3:0] code, input logic [1:0] mode, input bit blank);
        if (mode == 2'd0) return {3'b000, code};
        if (blank) return 7'h00;
        if (mode == 2'd2 && code > 4'd9) return 7'h00;
        return SEG_TBL[code];
    endfunction

    function automatic logic [7:0] ref_read(input logic [3:0] a);
        if (int'(a) < N) return m_dig[int'(a)];
        case (a)
            4'h8:    return m_ctrl;
            4'h9:    return m_pre[7:0];
            4'hA:    return m_pre[15:8];
            4'hB:    return 8'(m_idx);
            default: return 8'h00;
        endcase
    endfunction

    // Behavioural model: one step per rising clock edge.
    always @(posedge clk) begin
        int           s;
        int           val;
        bit           blank;
        logic [N-1:0] oh;
        if (rst) begin
            for (int j = 0; j < N; j++) m_dig[j] = 8'h00;
            m_ctrl  = 8'h00;
            m_pre   = 16'hFFFF;
            m_cnt   = 16'h0000;
            m_idx   = 0;
            exp_uo  = 8'h00;
            exp_sel = '0;
        end else begin
            s = m_ctrl[2] ? m_idx : 0;
            val = 0;
            for (int j = N - 1; j >= s; j--) val = val * 16 + int'(m_dig[j][3:0]);
            blank = LZB && m_ctrl[4] && (s != 0) && (val == 0);
            exp_uo = {m_dig[s][7], ref_seg(m_dig[s][3:0], m_ctrl[1:0], blank)} ^ (m_ctrl[3] ? 8'hFF : 8'h00);
            oh = '0;
            oh[s] = 1'b1;
            exp_sel = m_ctrl[3] ? ~oh : oh;
            if (m_ctrl[2]) begin
                if (m_cnt >= m_pre) begin
                    m_cnt = 16'h0000;
                    m_idx = (m_idx + 1) % N;
                end else begin
                    m_cnt = m_cnt + 16'h0001;
                end
            end else begin
                m_cnt = 16'h0000;
                m_idx = 0;
            end
            if (data_write) begin
                if (int'(address) < N) m_dig[int'(address)] = {data_in[7], 3'b000, data_in[3:0]};
                else if (address == 4'h8) m_ctrl = data_in & (LZB ? 8'h1F : 8'h0F);
                else if (address == 4'h9) m_pre[7:0] = data_in;
                else if (address == 4'hA) m_pre[15:8] = data_in;
            end
        end
    end

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        @(negedge clk);
        address    = a;
        data_in    = d;
        data_write = 1'b1;
        @(negedge clk);
        data_write = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        data_write = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (uo_out !== 8'h00) begin n_errors++; $display("FAIL reset_uo got %h want 00", uo_out); end
        n_checks++;
        if (digit_sel !== 4'b0000) begin n_errors++; $display("FAIL reset_sel got %b want 0000", digit_sel); end
        address = 4'h8; #1;
        n_checks++;
        if (data_out !== 8'h00) begin n_errors++; $display("FAIL reset_ctrl got %h want 00", data_out); end
        address = 4'h9; #1;
        n_checks++;
        if (data_out !== 8'hFF) begin n_errors++; $display("FAIL reset_pre_lo got %h want ff", data_out); end
        address = 4'hA; #1;
        n_checks++;
        if (data_out !== 8'hFF) begin n_errors++; $display("FAIL reset_pre_hi got %h want ff", data_out); end
        address = 4'hB; #1;
        n_checks++;
        if (data_out !== 8'h00) begin n_errors++; $display("FAIL reset_index got %h want 00", data_out); end
        rst = 1'b0;
    endtask

    task automatic test_static_hex;
        wr(4'h0, 8'h8A);
        wr(4'h8, 8'h01);
        @(negedge clk);
        n_checks++;
        if (uo_out !== 8'hF7) begin n_errors++; $display("FAIL hex_uo got %h want f7", uo_out); end
        n_checks++;
        if (digit_sel !== 4'b0001) begin n_errors++; $display("FAIL hex_sel got %b want 0001", digit_sel); end
    endtask

    task automatic test_bcd_blank;
        wr(4'h0, 8'h0C);
        wr(4'h8, 8'h02);
        @(negedge clk);
        n_checks++;
        if (uo_out !== 8'h00) begin n_errors++; $display("FAIL bcd_blank got %h want 00", uo_out); end
        wr(4'h0, 8'h07);
        @(negedge clk);
        n_checks++;
        if (uo_out !== 8'h07) begin n_errors++; $display("FAIL bcd_seven got %h want 07", uo_out); end
    endtask

    task automatic test_scan_wrap;
        logic [7:0]   want [N];
        logic [N-1:0] prev;
        int           run;
        bit           started;
        bit           saw_wrap;
        int           prev_idx;
        int           k;
        want = '{8'h06, 8'h5B, 8'h4F, 8'h66};
        wr(4'h9, 8'h03);
        wr(4'hA, 8'h00);
        for (int j = 0; j < N; j++) wr(4'(j), 8'(j + 1));
        wr(4'h8, 8'h05);
        address  = 4'hB;
        prev     = digit_sel;
        run      = 0;
        started  = 1'b0;
        saw_wrap = 1'b0;
        prev_idx = int'(data_out);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            k = -1;
            for (int j = 0; j < N; j++) if (digit_sel == (4'b0001 << j)) k = j;
            n_checks++;
            if (k < 0 || uo_out !== want[(k < 0) ? 0 : k]) begin
                n_errors++; $display("FAIL scan_seg sel %b uo %h", digit_sel, uo_out);
            end
            if (digit_sel == prev) begin
                run++;
            end else begin
                if (started) begin
                    n_checks++;
                    if (run != 4) begin n_errors++; $display("FAIL scan_hold got %0d want 4", run); end
                    n_checks++;
                    if (digit_sel !== {prev[N-2:0], prev[N-1]}) begin
                        n_errors++; $display("FAIL scan_order got %b after %b", digit_sel, prev);
                    end
                end
                started = 1'b1;
                run = 1;
                prev = digit_sel;
            end
            if (prev_idx == 3 && data_out == 8'h00) saw_wrap = 1'b1;
            prev_idx = int'(data_out);
        end
        n_checks++;
        if (!saw_wrap) begin n_errors++; $display("FAIL scan_index_wrap got 0 want 1"); end
    endtask

    task automatic test_invert_disable;
        bit found;
        wr(4'h8, 8'h0D);
        address = 4'hB;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (data_out == 8'h02) found = 1'b1;
        end
        n_checks++;
        if (!found) begin n_errors++; $display("FAIL inv_wait_index2 got timeout want index 2"); end
        wr(4'h8, 8'h09);
        address = 4'hB;
        @(negedge clk);
        n_checks++;
        if (data_out !== 8'h00) begin n_errors++; $display("FAIL inv_index got %h want 00", data_out); end
        n_checks++;
        if (digit_sel !== 4'b1110) begin n_errors++; $display("FAIL inv_sel got %b want 1110", digit_sel); end
        n_checks++;
        if (uo_out !== 8'hF9) begin n_errors++; $display("FAIL inv_uo got %h want f9", uo_out); end
    endtask

    task automatic test_lzb;
        logic [7:0] want;
        logic [3:0] seen;
        int         k;
        wr(4'h9, 8'h00);
        wr(4'h0, 8'h05);
        for (int j = 1; j < N; j++) wr(4'(j), 8'h00);
        wr(4'h8, 8'h15);
        address = 4'h8;
        @(negedge clk);
        n_checks++;
        if (data_out !== (LZB ? 8'h15 : 8'h05)) begin
            n_errors++; $display("FAIL lzb_ctrl got %h want %h", data_out, LZB ? 8'h15 : 8'h05);
        end
        seen = 4'b0000;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            k = -1;
            for (int j = 0; j < N; j++) if (digit_sel == (4'b0001 << j)) k = j;
            want = (k == 0) ? 8'h6D : (LZB ? 8'h00 : 8'h3F);
            n_checks++;
            if (k < 0 || uo_out !== want) begin
                n_errors++; $display("FAIL lzb_seg sel %b got %h want %h", digit_sel, uo_out, want);
            end
            if (k >= 0) seen[k] = 1'b1;
        end
        n_checks++;
        if (seen !== 4'b1111) begin n_errors++; $display("FAIL lzb_coverage got %b want 1111", seen); end
    endtask

    task automatic test_random;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            n_checks++;
            if (uo_out !== exp_uo) begin n_errors++; $display("FAIL rand_uo cyc %0d got %h want %h", c, uo_out, exp_uo); end
            n_checks++;
            if (digit_sel !== exp_sel) begin n_errors++; $display("FAIL rand_sel cyc %0d got %b want %b", c, digit_sel, exp_sel); end
            n_checks++;
            if (data_out !== ref_read(address)) begin
                n_errors++; $display("FAIL rand_read cyc %0d addr %h got %h want %h", c, address, data_out, ref_read(address));
            end
            ui_in      = 8'($urandom);
            address    = 4'($urandom_range(0, 15));
            data_write = ($urandom_range(0, 3) == 0);
            data_in    = 8'($urandom);
            if (address == 4'hA) data_in = 8'($urandom_range(0, 1));
            if (address == 4'h9) data_in = 8'($urandom_range(0, 7));
        end
    endtask

    task automatic test_reset_mid;
        wr(4'h9, 8'h01);
        wr(4'h8, 8'h0D);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (uo_out !== 8'h00) begin n_errors++; $display("FAIL midrst_uo got %h want 00", uo_out); end
        n_checks++;
        if (digit_sel !== 4'b0000) begin n_errors++; $display("FAIL midrst_sel got %b want 0000", digit_sel); end
        address = 4'hB; #1;
        n_checks++;
        if (data_out !== 8'h00) begin n_errors++; $display("FAIL midrst_index got %h want 00", data_out); end
        address = 4'h0; #1;
        n_checks++;
        if (data_out !== 8'h00) begin n_errors++; $display("FAIL midrst_digit0 got %h want 00", data_out); end
    endtask

    initial begin
        rst        = 1'b1;
        ui_in      = 8'h00;
        address    = 4'h0;
        data_write = 1'b0;
        data_in    = 8'h00;
        test_reset();
        test_static_hex();
        test_bcd_blank();
        test_scan_wrap();
        test_invert_disable();
        test_lzb();
        test_random();
        data_write = 1'b0;
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
